// File: rtl/bfsk_pkg.sv
// Shared definitions for the BFSK demodulator.
//   MIDSCALE   : offset-binary code for silence (zero signal level)
//   LDATA_DEF  : default bits per frame
//   NB_DEF     : default samples per bit
//   state_t    : demodulator FSM states
package bfsk_pkg;

    localparam int MIDSCALE  = 32768;
    localparam int LDATA_DEF = 8;
    localparam int NB_DEF    = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYMBOL = 2'd1,
        REARM  = 2'd2
    } state_t;

endpackage

// File: rtl/bfsk_demodulator_if.sv
// Sample-in / word-out bundle of the BFSK demodulator.
//   sample_valid : sample is consumed on this cycle
//   sample       : 16-bit offset-binary tone sample
//   data_out     : last decoded frame, LSB received first
//   data_valid   : one-cycle pulse when data_out updates
//   busy         : demodulator is inside a frame or re-arming
// master = sample source / word sink, slave = demodulator.
interface bfsk_demodulator_if #(
    parameter int LDATA = bfsk_pkg::LDATA_DEF
);
    logic             sample_valid;
    logic [15:0]      sample;
    logic [LDATA-1:0] data_out;
    logic             data_valid;
    logic             busy;

    modport master (
        output sample_valid,
        output sample,
        input  data_out,
        input  data_valid,
        input  busy
    );

    modport slave (
        input  sample_valid,
        input  sample,
        output data_out,
        output data_valid,
        output busy
    );
endinterface

// File: rtl/bfsk_zc_counter.sv
// Zero-crossing counter for one bit period.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : a sample is being processed this cycle
//   clear      : restart the count after this sample (sign is still stored)
//   sign       : sign bit of the current sample
//   count      : crossings of the current bit including this sample,
//                saturating at NB (combinational, valid while enable=1)
module bfsk_zc_counter #(
    parameter int NB = bfsk_pkg::NB_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic                    sign,
    output logic [$clog2(NB+1)-1:0] count
);
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(NB);

    logic          prev_sign_reg;
    logic [CW-1:0] count_reg;
    logic          crossing;

    assign crossing = sign ^ prev_sign_reg;

    // The decision on the last sample of a bit must see that sample's
    // crossing too, so the running total is exposed before it is stored.
    assign count = (crossing && (count_reg != COUNT_MAX)) ? count_reg + CW'(1) : count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sign_reg <= 1'b0;
            count_reg     <= '0;
        end else if (enable) begin
            // Sign history runs across bit boundaries; only the count clears.
            prev_sign_reg <= sign;
            count_reg     <= clear ? '0 : count;
        end
    end
endmodule

// File: rtl/bfsk_demodulator.sv
// Binary FSK demodulator: counts sign changes per bit period and decides
// 1 for the higher-frequency tone. A frame starts on the first sample
// outside the idle band; after LDATA bits the word is presented with a
// one-cycle data_valid pulse, then a run of IDLE_LEN in-band samples is
// required before another frame may start.
//   CLOCK_50 : sole clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   bus      : slave side of bfsk_demodulator_if (samples in, word out)
module bfsk_demodulator
    import bfsk_pkg::*;
#(
    parameter int LDATA     = LDATA_DEF,
    parameter int NB        = NB_DEF,
    parameter int DEADBAND  = 1024,
    parameter int ZC_THRESH = 20,
    parameter int IDLE_LEN  = 16
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    bfsk_demodulator_if.slave bus
);
    localparam int SCW = $clog2(NB);
    localparam int ZCW = $clog2(NB + 1);
    localparam int BIW = $clog2(LDATA + 1);
    localparam int RCW = $clog2(IDLE_LEN + 1);

    localparam logic [16:0]    MID17      = 17'(MIDSCALE);
    localparam logic [16:0]    BAND17     = 17'(DEADBAND);
    localparam logic [SCW-1:0] LAST_SMP   = SCW'(NB - 1);
    localparam logic [BIW-1:0] LAST_BIT   = BIW'(LDATA - 1);
    localparam logic [RCW-1:0] LAST_RUN   = RCW'(IDLE_LEN - 1);
    localparam logic [ZCW-1:0] THRESH     = ZCW'(ZC_THRESH);

    state_t           state_reg;
    logic [SCW-1:0]   sample_cnt_reg;
    logic [BIW-1:0]   bit_idx_reg;
    logic [RCW-1:0]   run_cnt_reg;
    logic [LDATA-1:0] shift_reg;
    logic [LDATA-1:0] data_out_reg;
    logic             data_valid_reg;
    logic             busy_reg;

    logic [16:0]      deviation;
    logic             in_band;
    logic             sign;
    logic             zc_enable;
    logic             zc_clear;
    logic [ZCW-1:0]   zc_count;
    logic             bit_end;
    logic             bit_val;
    logic [LDATA-1:0] word_next;

    // Distance from midscale; sample[15] tells which side we are on.
    assign deviation = bus.sample[15] ? ({1'b0, bus.sample} - MID17)
                                      : (MID17 - {1'b0, bus.sample});
    assign in_band   = (deviation <= BAND17);
    assign sign      = bus.sample[15];

    // In IDLE the starting sample only seeds the sign history.
    assign zc_enable = bus.sample_valid &&
                       (((state_reg == IDLE) && !in_band) || (state_reg == SYMBOL));
    assign zc_clear  = (state_reg == IDLE) || (sample_cnt_reg == LAST_SMP);
    assign bit_end   = (state_reg == SYMBOL) && bus.sample_valid && (sample_cnt_reg == LAST_SMP);
    assign bit_val   = (zc_count >= THRESH);

    bfsk_zc_counter #(
        .NB(NB)
    ) u_zc (
        .clk    (CLOCK_50),
        .rst_n  (RESET_N),
        .enable (zc_enable),
        .clear  (zc_clear),
        .sign   (sign),
        .count  (zc_count)
    );

    // Word with the finishing bit dropped into its slot, so the last bit
    // of a frame can go straight to data_out.
    generate
        for (genvar gi = 0; gi < LDATA; gi++) begin : g_word
            assign word_next[gi] = (bit_end && (bit_idx_reg == BIW'(gi))) ? bit_val : shift_reg[gi];
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= IDLE;
            sample_cnt_reg <= '0;
            bit_idx_reg    <= '0;
            run_cnt_reg    <= '0;
            shift_reg      <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            if (bus.sample_valid) begin
                case (state_reg)
                    IDLE: begin
                        if (!in_band) begin
                            // This sample is sample 0 of bit 0.
                            state_reg      <= SYMBOL;
                            busy_reg       <= 1'b1;
                            sample_cnt_reg <= SCW'(1);
                            bit_idx_reg    <= '0;
                            shift_reg      <= '0;
                        end
                    end
                    SYMBOL: begin
                        shift_reg <= word_next;
                        if (bit_end) begin
                            sample_cnt_reg <= '0;
                            if (bit_idx_reg == LAST_BIT) begin
                                data_out_reg   <= word_next;
                                data_valid_reg <= 1'b1;
                                bit_idx_reg    <= '0;
                                run_cnt_reg    <= '0;
                                state_reg      <= REARM;
                            end else begin
                                bit_idx_reg <= bit_idx_reg + BIW'(1);
                            end
                        end else begin
                            sample_cnt_reg <= sample_cnt_reg + SCW'(1);
                        end
                    end
                    REARM: begin
                        if (!in_band) begin
                            run_cnt_reg <= '0;
                        end else if (run_cnt_reg == LAST_RUN) begin
                            run_cnt_reg <= '0;
                            state_reg   <= IDLE;
                            busy_reg    <= 1'b0;
                        end else begin
                            run_cnt_reg <= run_cnt_reg + RCW'(1);
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_out   = data_out_reg;
    assign bus.data_valid = data_valid_reg;
    assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_bfsk_demodulator.sv
// Directed bench for bfsk_demodulator: square-wave tones (period 64 for a
// 0, period 16 for a 1, +/-16000 around midscale), LSB first, NB=256.
module tb_bfsk_demodulator;
    localparam logic [15:0] MID   = 16'd32768;
    localparam logic [15:0] HI    = 16'd48768;
    localparam logic [15:0] LO    = 16'd16768;
    localparam int          FRAME = 8 * 256;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;

    int   total = 0;
    int   bad   = 0;
    int   pulse_cnt = 0;
    logic [7:0] last_word = 8'h00;
    logic [7:0] prev_word = 8'h00;

    bfsk_demodulator_if #(.LDATA(8)) bus ();

    bfsk_demodulator #(
        .LDATA     (8),
        .NB        (256),
        .DEADBAND  (1024),
        .ZC_THRESH (20),
        .IDLE_LEN  (16)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Word receiver: one line per received word.
    always @(negedge CLOCK_50) begin
        if (bus.data_valid === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            prev_word <= last_word;
            last_word <= bus.data_out;
            $display("rx word %02h at %0t", bus.data_out, $time);
        end
    end

    function automatic logic [15:0] tone(input logic b, input int n);
        int p;
        p = b ? 16 : 64;
        return ((n % p) < (p / 2)) ? HI : LO;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] s);
        bus.sample_valid = v;
        bus.sample       = s;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, MID);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit toggle);
        for (int n = 0; n < FRAME; n++) begin
            step(1'b1, tone(d[n / 256], n));
            if (toggle) step(1'b0, 16'h0000);
        end
    endtask

    initial begin
        int p0;
        bus.sample_valid = 1'b0;
        bus.sample       = MID;

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_dv",   32'(bus.data_valid), 32'h0);
        chk("reset_dout", 32'(bus.data_out), 32'h0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        idle_n(4);

        // Frame 0xAA with exact pulse timing
        p0 = pulse_cnt;
        for (int n = 0; n < FRAME - 1; n++) step(1'b1, tone(1'b0 ^ (8'hAA >> (n / 256)) & 1'b1, n));
        chk("aa_no_early_dv",    32'(bus.data_valid), 32'h0);
        chk("aa_no_early_pulse", 32'(pulse_cnt - p0), 32'h0);
        chk("aa_busy_in_frame",  32'(bus.busy), 32'h1);
        step(1'b1, tone(1'b1, FRAME - 1));
        chk("aa_dv_on_time", 32'(bus.data_valid), 32'h1);
        chk("aa_dout",       32'(bus.data_out), 32'hAA);
        step(1'b1, MID);
        chk("aa_dv_one_cycle", 32'(bus.data_valid), 32'h0);
        chk("aa_pulses",       32'(pulse_cnt - p0), 32'h1);
        chk("aa_busy_rearm",   32'(bus.busy), 32'h1);
        idle_n(14);
        chk("rearm_15_busy", 32'(bus.busy), 32'h1);
        idle_n(1);
        chk("rearm_16_idle", 32'(bus.busy), 32'h0);
        idle_n(16);

        // Back-to-back frames 0x00 and 0xFF separated by 32 midscale
        p0 = pulse_cnt;
        send_frame(8'h00, 1'b0);
        idle_n(32);
        send_frame(8'hFF, 1'b0);
        idle_n(2);
        chk("b2b_pulses", 32'(pulse_cnt - p0), 32'h2);
        chk("b2b_first",  32'(prev_word), 32'h00);
        chk("b2b_second", 32'(last_word), 32'hFF);
        idle_n(30);
        chk("b2b_hold", 32'(bus.data_out), 32'hFF);

        // Frame 0x5A with sample_valid toggling (garbage on invalid cycles)
        p0 = pulse_cnt;
        send_frame(8'h5A, 1'b1);
        idle_n(2);
        chk("tog_pulses", 32'(pulse_cnt - p0), 32'h1);
        chk("tog_word",   32'(last_word), 32'h5A);
        idle_n(16);

        // Reset during bit 3 discards the frame
        p0 = pulse_cnt;
        for (int n = 0; n < 3 * 256 + 10; n++) step(1'b1, tone(1'b1, n));
        #2 RESET_N = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        chk("mid_rst_dout", 32'(bus.data_out), 32'h0);
        chk("mid_rst_dv",   32'(bus.data_valid), 32'h0);
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        chk("mid_rst_no_pulse", 32'(pulse_cnt - p0), 32'h0);
        send_frame(8'h3C, 1'b0);
        idle_n(2);
        chk("post_rst_pulses", 32'(pulse_cnt - p0), 32'h1);
        chk("post_rst_word",   32'(bus.data_out), 32'h3C);
        idle_n(16);

        // Deadband edges
        for (int i = 0; i < 40; i++) step(1'b1, (i % 2 == 0) ? 16'd33792 : 16'd31744);
        chk("band_stay_idle", 32'(bus.busy), 32'h0);
        step(1'b1, 16'd33793);
        chk("band_plus_start", 32'(bus.busy), 32'h1);
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        step(1'b1, 16'd31744);
        chk("band_minus_edge_idle", 32'(bus.busy), 32'h0);
        step(1'b1, 16'd31743);
        chk("band_minus_start", 32'(bus.busy), 32'h1);
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

        // Only 15 in-band samples after a frame: tone must not start a frame
        p0 = pulse_cnt;
        send_frame(8'h96, 1'b0);
        idle_n(15);
        chk("short_gap_word",  32'(last_word), 32'h96);
        chk("short_gap_busy",  32'(bus.busy), 32'h1);
        send_frame(8'hFF, 1'b0);
        idle_n(1);
        chk("short_gap_pulses", 32'(pulse_cnt - p0), 32'h1);
        chk("short_gap_rearm",  32'(bus.busy), 32'h1);
        chk("short_gap_hold",   32'(bus.data_out), 32'h96);
        idle_n(15);
        chk("short_gap_release", 32'(bus.busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bfsk_demodulator.md
BFSK_DEMODULATOR -- requirements
Module: bfsk_demodulator

Interface
REQ-001 SHALL have parameter LDATA, default 8: bits per frame.
REQ-002 SHALL have parameter NB, default 256: samples per bit.
REQ-003 SHALL have parameter DEADBAND, default 1024: half-width of the idle band around MIDSCALE (32768).
REQ-004 SHALL have parameter ZC_THRESH, default 20: zero-crossing count at or above which a bit decodes as 1.
REQ-005 SHALL have parameter IDLE_LEN, default 16: consecutive in-band samples needed to re-arm.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port CLOCK_50, input, 1: sole clock, rising edge.
REQ-008 SHALL have port RESET_N, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port sample_valid, input, 1: sample is consumed on this cycle.
REQ-010 SHALL have port sample, input, 16: offset-binary tone sample, MIDSCALE = silence.
REQ-011 SHALL have port data_out, output, LDATA: last decoded frame, LSB received first.
REQ-012 SHALL have port data_valid, output, 1: one-cycle pulse when data_out updates.
REQ-013 SHALL have port busy, output, 1: high in SYMBOL and REARM.

Function
REQ-014 SHALL treat in-band as |sample - 32768| <= DEADBAND; sign = sample[15].
REQ-015 SHALL change state, counters or sign history only on cycles with sample_valid=1.
REQ-016 SHALL implement states IDLE, SYMBOL and REARM.
REQ-017 IDLE: the first out-of-band sample SHALL go to SYMBOL, count as sample 0 of bit 0, and load prev_sign with its sign; crossing count starts at 0.
REQ-018 SYMBOL: each sample whose sign differs from prev_sign SHALL increment the crossing count, saturating at NB; prev_sign SHALL update every sample.
REQ-019 Sign history SHALL carry across bit boundaries, so a crossing on sample 0 of bit k>0 counts toward bit k.
REQ-020 On sample NB-1 of bit k, bit k SHALL be (count >= ZC_THRESH), written to shift position k; count SHALL clear and bit index SHALL advance; the higher-frequency tone is 1.
REQ-021 After bit LDATA-1, data_out SHALL load the assembled word and data_valid SHALL pulse on the next cycle (latency 1), then go to REARM.
REQ-022 REARM: the state SHALL return to IDLE after IDLE_LEN consecutive in-band samples; any out-of-band sample SHALL reset the run counter.
REQ-023 In-band samples inside SYMBOL SHALL be processed normally and SHALL NOT abort the frame.
REQ-024 data_out SHALL hold its value until the next completed frame.
REQ-025 Counter widths: sample count $clog2(NB), crossing count $clog2(NB+1), bit index $clog2(LDATA+1), run count $clog2(IDLE_LEN+1).

Reset
REQ-026 Reset SHALL asynchronously force state=IDLE, all counters=0, prev_sign=0, shift register=0, data_out=0, data_valid=0 and busy=0.
REQ-027 Reset mid-frame SHALL discard the partial frame without asserting data_valid; decoding SHALL restart at the next out-of-band sample after release.

Structure
REQ-028 Shared package bfsk_pkg SHALL hold MIDSCALE, the defaults for LDATA and NB, and the state enum.
REQ-029 Sub-module bfsk_zc_counter SHALL own sign history, crossing count and saturation, with inputs clear, enable and sign.
REQ-030 The top level SHALL own the FSM, sample and bit counters, shift register and REARM run counter.

Verification
REQ-031 Modulator default frame 0xAA: tone0 period 64 samples, tone1 period 16, NB=256, amplitude ±16000, sample_valid=1 -> one data_valid pulse and data_out=0xAA, 8*256+1 cycles after the first tone sample.
REQ-032 Frames 0x00 then 0xFF, separated by 32 MIDSCALE samples -> two pulses with 0x00 and 0xFF; the second frame is not missed.
REQ-033 sample_valid toggling 1/0 during frame 0x5A -> data_out=0x5A after 2048 valid samples, with timing stretched about 2x.
REQ-034 RESET_N low at bit 3 of a frame -> no data_valid, busy=0 and data_out=0; the next full frame 0x3C decodes correctly.
REQ-035 Steady-MIDSCALE noise of ±DEADBAND -> never leaves IDLE; a ±DEADBAND+1 sample starts SYMBOL.
REQ-036 Frame followed by only 15 in-band samples, then tone -> stays in REARM, and the tone does not start a new frame.
